// File: rtl/dmmu_xlate_pkg.sv
// dmmu_xlate_pkg: shared constants and types for the load/store address
// translation stage (dmmu_xlate) and its mode/exception checker (dmmu_chk).
//   - exception codes reported on resp_ecode
//   - field positions inside the direct-map window CSRs
//   - TLB page-size encodings
//   - response-stage state type and the dmw_hit helper
package dmmu_xlate_pkg;

   localparam logic [5:0] ECODE_NONE = 6'h00;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;
   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;

   localparam int unsigned DMW_VSEG_HI = 31;
   localparam int unsigned DMW_VSEG_LO = 29;
   localparam int unsigned DMW_PSEG_HI = 27;
   localparam int unsigned DMW_PSEG_LO = 25;
   localparam int unsigned DMW_MAT_HI  = 5;
   localparam int unsigned DMW_MAT_LO  = 4;
   localparam int unsigned DMW_PLV3    = 3;
   localparam int unsigned DMW_PLV0    = 0;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_4M = 6'd22;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_t;

   // A window only serves PLV0 or PLV3; PLV1/PLV2 never hit.
   function automatic logic dmw_hit(input logic [31:0] dmw,
                                    input logic [31:0] va,
                                    input logic [1:0]  plv);
      logic plv_ok;
      plv_ok = ((plv == 2'd0) && dmw[DMW_PLV0]) || ((plv == 2'd3) && dmw[DMW_PLV3]);
      return (va[31:29] == dmw[DMW_VSEG_HI:DMW_VSEG_LO]) && plv_ok;
   endfunction

endpackage

// File: rtl/dmmu_xlate_if.sv
// dmmu_xlate_if: request/response handshake bundle of the translation stage.
//   req_valid/req_ready/req_vaddr/req_wr : request from the LSU
//   resp_valid/resp_ready/resp_*          : registered translation result
// Modports: master = requester/consumer side, slave = dmmu_xlate.
interface dmmu_xlate_if #(
   parameter int unsigned TLBNUM = 16
);
   localparam int unsigned IW = $clog2(TLBNUM);

   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_vaddr;
   logic          req_wr;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_paddr;
   logic [1:0]    resp_mat;
   logic          resp_ex;
   logic [5:0]    resp_ecode;
   logic [31:0]   resp_badv;
   logic [IW-1:0] resp_tlb_idx;

   modport master (
      output req_valid, req_vaddr, req_wr, resp_ready,
      input  req_ready, resp_valid, resp_paddr, resp_mat, resp_ex,
             resp_ecode, resp_badv, resp_tlb_idx
   );

   modport slave (
      input  req_valid, req_vaddr, req_wr, resp_ready,
      output req_ready, resp_valid, resp_paddr, resp_mat, resp_ex,
             resp_ecode, resp_badv, resp_tlb_idx
   );
endinterface

// File: rtl/dmmu_xlate_chk.sv
// dmmu_chk: combinational mode select and exception/PA computation.
// Inputs : CSR mode bits (da, pg, plv, datm), DMW CSRs, VA and store flag,
//          TLB search-port-1 results.
// Outputs: paddr, mat, ex, ecode, tlb_idx for the response register.
// Build option: DMMU_DMW_EN enables the direct-map windows; otherwise
// paged mode always goes through the TLB and dmw0/dmw1 are ignored.
module dmmu_chk
   import dmmu_xlate_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IW    = $clog2(TLBNUM)
) (
   input  logic          da,
   input  logic          pg,
   input  logic [1:0]    plv,
   input  logic [1:0]    datm,
   input  logic [31:0]   dmw0,
   input  logic [31:0]   dmw1,
   input  logic [31:0]   vaddr,
   input  logic          wr,
   input  logic          s1_found,
   input  logic [IW-1:0] s1_index,
   input  logic [19:0]   s1_ppn,
   input  logic [5:0]    s1_ps,
   input  logic [1:0]    s1_plv,
   input  logic [1:0]    s1_mat,
   input  logic          s1_d,
   input  logic          s1_v,
   output logic [31:0]   paddr,
   output logic [1:0]    mat,
   output logic          ex,
   output logic [5:0]    ecode,
   output logic [IW-1:0] tlb_idx
);

`ifndef DMMU_DMW_EN
   logic unused_dmw;
   assign unused_dmw = ^{dmw0, dmw1};
`endif

   always_comb begin
      paddr   = vaddr;
      mat     = datm;
      ex      = 1'b0;
      ecode   = ECODE_NONE;
      tlb_idx = '0;
      // DA=0 with PG=0 is an illegal CSR combination; it falls back to DA.
      if (da || !pg) begin
         paddr = vaddr;
      end
`ifdef DMMU_DMW_EN
      else if (dmw_hit(dmw0, vaddr, plv)) begin
         paddr = {dmw0[DMW_PSEG_HI:DMW_PSEG_LO], vaddr[28:0]};
         mat   = dmw0[DMW_MAT_HI:DMW_MAT_LO];
      end
      else if (dmw_hit(dmw1, vaddr, plv)) begin
         paddr = {dmw1[DMW_PSEG_HI:DMW_PSEG_LO], vaddr[28:0]};
         mat   = dmw1[DMW_MAT_HI:DMW_MAT_LO];
      end
`endif
      else begin
         paddr = '0;
         mat   = '0;
         if (!s1_found) begin
            ex    = 1'b1;
            ecode = ECODE_TLBR;
         end else begin
            tlb_idx = s1_index;
            if (!s1_v) begin
               ex    = 1'b1;
               ecode = wr ? ECODE_PIS : ECODE_PIL;
            end else if (plv > s1_plv) begin
               ex    = 1'b1;
               ecode = ECODE_PPI;
            end else if (wr && !s1_d) begin
               ex    = 1'b1;
               ecode = ECODE_PME;
            end else begin
               paddr = (s1_ps == PS_4M) ? {s1_ppn[19:10], vaddr[21:0]}
                                        : {s1_ppn, vaddr[11:0]};
               mat   = s1_mat;
            end
         end
      end
   end

endmodule

// File: rtl/dmmu_xlate.sv
// dmmu_xlate: load/store address-translation stage in front of TLB port 1.
// Ports:
//   clk, resetn (sync, active low), flush (kills request and held response)
//   bus        : dmmu_xlate_if.slave request/response handshake
//   csr_*      : CRMD DA/PG/PLV/DATM, ASID, DMW0/DMW1
//   s1_vppn/s1_va_bit12/s1_asid : combinational TLB search inputs
//   s1_found/index/ppn/ps/plv/mat/d/v : TLB search results
// Build option: DMMU_DMW_EN enables direct-map window translation.
// The result is held in a one-entry output register with 1-cycle latency.
module dmmu_xlate
   import dmmu_xlate_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IW    = $clog2(TLBNUM)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   dmmu_xlate_if.slave          bus,
   input  logic                 csr_crmd_da,
   input  logic                 csr_crmd_pg,
   input  logic [1:0]           csr_crmd_plv,
   input  logic [1:0]           csr_crmd_datm,
   input  logic [9:0]           csr_asid,
   input  logic [31:0]          csr_dmw0,
   input  logic [31:0]          csr_dmw1,
   output logic [18:0]          s1_vppn,
   output logic                 s1_va_bit12,
   output logic [9:0]           s1_asid,
   input  logic                 s1_found,
   input  logic [IW-1:0]        s1_index,
   input  logic [19:0]          s1_ppn,
   input  logic [5:0]           s1_ps,
   input  logic [1:0]           s1_plv,
   input  logic [1:0]           s1_mat,
   input  logic                 s1_d,
   input  logic                 s1_v
);

   rsp_state_t    state_q, state_d;
   logic          accept;
   logic [31:0]   c_paddr;
   logic [1:0]    c_mat;
   logic          c_ex;
   logic [5:0]    c_ecode;
   logic [IW-1:0] c_idx;
   logic [31:0]   paddr_q, badv_q;
   logic [1:0]    mat_q;
   logic          ex_q;
   logic [5:0]    ecode_q;
   logic [IW-1:0] idx_q;

   assign s1_vppn     = bus.req_vaddr[31:13];
   assign s1_va_bit12 = bus.req_vaddr[12];
   assign s1_asid     = csr_asid;

   dmmu_chk #(.TLBNUM(TLBNUM)) u_chk (
      .da       (csr_crmd_da),
      .pg       (csr_crmd_pg),
      .plv      (csr_crmd_plv),
      .datm     (csr_crmd_datm),
      .dmw0     (csr_dmw0),
      .dmw1     (csr_dmw1),
      .vaddr    (bus.req_vaddr),
      .wr       (bus.req_wr),
      .s1_found (s1_found),
      .s1_index (s1_index),
      .s1_ppn   (s1_ppn),
      .s1_ps    (s1_ps),
      .s1_plv   (s1_plv),
      .s1_mat   (s1_mat),
      .s1_d     (s1_d),
      .s1_v     (s1_v),
      .paddr    (c_paddr),
      .mat      (c_mat),
      .ex       (c_ex),
      .ecode    (c_ecode),
      .tlb_idx  (c_idx)
   );

   assign bus.req_ready = !flush && ((state_q == ST_EMPTY) || bus.resp_ready);
   assign accept        = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_EMPTY;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush)                                   state_d = ST_EMPTY;
      else if (accept)                             state_d = ST_FULL;
      else if (state_q == ST_FULL && bus.resp_ready) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         paddr_q <= '0;
         mat_q   <= '0;
         ex_q    <= 1'b0;
         ecode_q <= '0;
         badv_q  <= '0;
         idx_q   <= '0;
      end else if (accept) begin
         paddr_q <= c_paddr;
         mat_q   <= c_mat;
         ex_q    <= c_ex;
         ecode_q <= c_ecode;
         badv_q  <= bus.req_vaddr;
         idx_q   <= c_idx;
      end
   end

   assign bus.resp_valid   = (state_q == ST_FULL);
   assign bus.resp_paddr   = paddr_q;
   assign bus.resp_mat     = mat_q;
   assign bus.resp_ex      = ex_q;
   assign bus.resp_ecode   = ecode_q;
   assign bus.resp_badv    = badv_q;
   assign bus.resp_tlb_idx = idx_q;

endmodule

// File: tb/tb_dmmu_xlate.sv
// tb_dmmu_xlate: table-driven bench for dmmu_xlate plus hand-written
// backpressure, flush and mid-transaction reset sequences.
module tb_dmmu_xlate;

   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IW     = $clog2(TLBNUM);

   typedef struct {
      logic          da, pg;
      logic [1:0]    plv, datm;
      logic [31:0]   dmw0, va;
      logic          wr, found;
      logic [IW-1:0] idx;
      logic [19:0]   ppn;
      logic [5:0]    ps;
      logic [1:0]    s1plv, s1mat;
      logic          d, v;
      logic [31:0]   e_paddr;
      logic [1:0]    e_mat;
      logic          e_ex;
      logic [5:0]    e_ecode;
      logic [IW-1:0] e_idx;
   } vec_t;

   localparam int NV = 13;

`ifdef DMMU_DMW_EN
   localparam logic [31:0]   E2_PADDR = 32'h0000_1234;
   localparam logic [1:0]    E2_MAT   = 2'd1;
   localparam logic [IW-1:0] E2_IDX   = 4'd0;
`else
   localparam logic [31:0]   E2_PADDR = 32'h0005_5234;
   localparam logic [1:0]    E2_MAT   = 2'd2;
   localparam logic [IW-1:0] E2_IDX   = 4'd2;
`endif

   logic          clk = 1'b0;
   logic          resetn, flush;
   logic          csr_crmd_da, csr_crmd_pg;
   logic [1:0]    csr_crmd_plv, csr_crmd_datm;
   logic [9:0]    csr_asid;
   logic [31:0]   csr_dmw0, csr_dmw1;
   logic [18:0]   s1_vppn;
   logic          s1_va_bit12;
   logic [9:0]    s1_asid;
   logic          s1_found;
   logic [IW-1:0] s1_index;
   logic [19:0]   s1_ppn;
   logic [5:0]    s1_ps;
   logic [1:0]    s1_plv, s1_mat;
   logic          s1_d, s1_v;

   int checks   = 0;
   int failures = 0;
   vec_t vecs [NV];

   dmmu_xlate_if #(.TLBNUM(TLBNUM)) bus ();

   dmmu_xlate #(.TLBNUM(TLBNUM)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .flush         (flush),
      .bus           (bus.slave),
      .csr_crmd_da   (csr_crmd_da),
      .csr_crmd_pg   (csr_crmd_pg),
      .csr_crmd_plv  (csr_crmd_plv),
      .csr_crmd_datm (csr_crmd_datm),
      .csr_asid      (csr_asid),
      .csr_dmw0      (csr_dmw0),
      .csr_dmw1      (csr_dmw1),
      .s1_vppn       (s1_vppn),
      .s1_va_bit12   (s1_va_bit12),
      .s1_asid       (s1_asid),
      .s1_found      (s1_found),
      .s1_index      (s1_index),
      .s1_ppn        (s1_ppn),
      .s1_ps         (s1_ps),
      .s1_plv        (s1_plv),
      .s1_mat        (s1_mat),
      .s1_d          (s1_d),
      .s1_v          (s1_v)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic da, pg, input logic [1:0] plv, datm, input logic [31:0] dmw0, va,
      input logic wr, found, input logic [IW-1:0] idx, input logic [19:0] ppn,
      input logic [5:0] ps, input logic [1:0] s1plv, s1mat, input logic d, v,
      input logic [31:0] e_paddr, input logic [1:0] e_mat, input logic e_ex,
      input logic [5:0] e_ecode, input logic [IW-1:0] e_idx);
      vec_t r;
      r.da = da; r.pg = pg; r.plv = plv; r.datm = datm; r.dmw0 = dmw0; r.va = va;
      r.wr = wr; r.found = found; r.idx = idx; r.ppn = ppn; r.ps = ps;
      r.s1plv = s1plv; r.s1mat = s1mat; r.d = d; r.v = v;
      r.e_paddr = e_paddr; r.e_mat = e_mat; r.e_ex = e_ex; r.e_ecode = e_ecode;
      r.e_idx = e_idx;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      csr_crmd_da   = v.da;
      csr_crmd_pg   = v.pg;
      csr_crmd_plv  = v.plv;
      csr_crmd_datm = v.datm;
      csr_dmw0      = v.dmw0;
      bus.req_vaddr = v.va;
      bus.req_wr    = v.wr;
      s1_found      = v.found;
      s1_index      = v.idx;
      s1_ppn        = v.ppn;
      s1_ps         = v.ps;
      s1_plv        = v.s1plv;
      s1_mat        = v.s1mat;
      s1_d          = v.d;
      s1_v          = v.v;
   endtask

   task automatic check_resp(input string tag, input vec_t v);
      check({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      check({tag, "_paddr"}, bus.resp_paddr, v.e_paddr);
      check({tag, "_mat"},   {30'd0, bus.resp_mat}, {30'd0, v.e_mat});
      check({tag, "_ex"},    {31'd0, bus.resp_ex}, {31'd0, v.e_ex});
      check({tag, "_ecode"}, {26'd0, bus.resp_ecode}, {26'd0, v.e_ecode});
      check({tag, "_badv"},  bus.resp_badv, v.va);
      check({tag, "_idx"},   {{(32-IW){1'b0}}, bus.resp_tlb_idx}, {{(32-IW){1'b0}}, v.e_idx});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd0);
      check({tag, "_paddr"}, bus.resp_paddr, 32'd0);
      check({tag, "_mat"},   {30'd0, bus.resp_mat}, 32'd0);
      check({tag, "_ex"},    {31'd0, bus.resp_ex}, 32'd0);
      check({tag, "_ecode"}, {26'd0, bus.resp_ecode}, 32'd0);
      check({tag, "_badv"},  bus.resp_badv, 32'd0);
      check({tag, "_idx"},   {{(32-IW){1'b0}}, bus.resp_tlb_idx}, 32'd0);
   endtask

   initial begin
      //          da pg plv datm dmw0          va            wr fnd idx ppn       ps  s1plv mat d  v   paddr          mat ex ecode idx
      vecs[0]  = mk(1, 0, 0, 1, 32'h0,        32'h1C00_0100, 0, 0, 0, 20'h0,     12, 0, 0, 0, 0, 32'h1C00_0100, 1, 0, 6'h00, 0);
      vecs[1]  = mk(0, 0, 3, 2, 32'h0,        32'h1234_5678, 1, 0, 0, 20'h0,     12, 0, 0, 0, 0, 32'h1234_5678, 2, 0, 6'h00, 0);
      vecs[2]  = mk(0, 1, 0, 0, 32'hA000_0011, 32'hA000_1234, 0, 1, 2, 20'h00055, 12, 0, 2, 1, 1, E2_PADDR,      E2_MAT, 0, 6'h00, E2_IDX);
      vecs[3]  = mk(0, 1, 0, 3, 32'h0,        32'h0040_1ABC, 0, 1, 5, 20'h12345, 12, 0, 1, 1, 1, 32'h1234_5ABC, 1, 0, 6'h00, 5);
      vecs[4]  = mk(0, 1, 0, 3, 32'h0,        32'h0040_1ABC, 0, 1, 7, 20'h00C00, 22, 0, 0, 1, 1, 32'h00C0_1ABC, 0, 0, 6'h00, 7);
      vecs[5]  = mk(0, 1, 0, 3, 32'h0,        32'h0040_2000, 0, 0, 0, 20'h12345, 12, 0, 1, 1, 1, 32'h0,         0, 1, 6'h3F, 0);
      vecs[6]  = mk(0, 1, 0, 3, 32'h0,        32'h0040_3000, 1, 1, 3, 20'h12345, 12, 0, 1, 1, 0, 32'h0,         0, 1, 6'h02, 3);
      vecs[7]  = mk(0, 1, 0, 3, 32'h0,        32'h0040_4000, 0, 1, 3, 20'h12345, 12, 0, 1, 1, 0, 32'h0,         0, 1, 6'h01, 3);
      vecs[8]  = mk(0, 1, 3, 3, 32'h0,        32'h0040_5000, 0, 1, 4, 20'h12345, 12, 0, 1, 1, 1, 32'h0,         0, 1, 6'h07, 4);
      vecs[9]  = mk(0, 1, 0, 3, 32'h0,        32'h0040_6000, 1, 1, 6, 20'h12345, 12, 0, 1, 0, 1, 32'h0,         0, 1, 6'h04, 6);
      vecs[10] = mk(0, 1, 3, 3, 32'h0,        32'h0040_7000, 1, 1, 6, 20'h12345, 12, 0, 1, 0, 1, 32'h0,         0, 1, 6'h07, 6);
      vecs[11] = mk(0, 1, 1, 3, 32'hA000_0009, 32'hA000_1234, 0, 1, 1, 20'h00077, 12, 3, 1, 0, 1, 32'h0007_7234, 1, 0, 6'h00, 1);
      vecs[12] = mk(0, 1, 2, 0, 32'h0,        32'hFFFF_F000, 1, 1, 15, 20'hFFFFF, 12, 2, 3, 1, 1, 32'hFFFF_F000, 3, 0, 6'h00, 15);

      resetn = 1'b0;
      flush  = 1'b0;
      csr_asid = 10'h155;
      csr_dmw1 = 32'h0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      drive(vecs[0]);

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
      resetn = 1'b1;

      // table: back-to-back requests with the consumer always ready
      bus.resp_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         bus.req_valid = 1'b1;
         #1;
         check($sformatf("v%0d_s1_vppn", i), {13'd0, s1_vppn}, {13'd0, vecs[i].va[31:13]});
         check($sformatf("v%0d_s1_b12", i), {31'd0, s1_va_bit12}, {31'd0, vecs[i].va[12]});
         check($sformatf("v%0d_s1_asid", i), {22'd0, s1_asid}, 32'h155);
         @(posedge clk);
         #1;
         check_resp($sformatf("v%0d", i), vecs[i]);
      end
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("drain_valid", {31'd0, bus.resp_valid}, 32'd0);

      // backpressure: hold 3 cycles, new request must wait, then back-to-back
      drive(vecs[3]);
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      check_resp("bp_first", vecs[3]);
      drive(vecs[0]);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("bp%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
         @(posedge clk);
         #1;
         check_resp($sformatf("bp%0d_hold", c), vecs[3]);
      end
      bus.resp_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_resp("bp_b2b", vecs[0]);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_empty", {31'd0, bus.resp_valid}, 32'd0);

      // flush while full with a request pending and the consumer ready
      drive(vecs[3]);
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      check_resp("fl_full", vecs[3]);
      drive(vecs[0]);
      flush          = 1'b1;
      bus.resp_ready = 1'b1;
      #1;
      check("fl_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("fl_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("fl_no_capture", bus.resp_paddr, 32'h1234_5ABC);
      check("fl_badv_kept", bus.resp_badv, 32'h0040_1ABC);
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("fl_after_valid", {31'd0, bus.resp_valid}, 32'd0);

      // reset while full with a request pending
      drive(vecs[3]);
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      check_resp("rs_full", vecs[3]);
      drive(vecs[0]);
      resetn         = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_zero("rs_mid");
      resetn        = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rs_after_valid", {31'd0, bus.resp_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
